// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
//
// Health monitor for a divided clock. The monitored clock is sampled as data in
// the clk_in domain. Each rising edge produces a period measurement in clk_in
// cycles. A run of in-tolerance periods declares lock. A bad period, or a
// clock that stops while locked, drops the monitor into a sticky fault state
// that only fault_clr can leave.
//
// Optional feature: define CLKMON_DUTY_EN to add the high_time output. When it
// is enabled, a period is only good if its duty cycle is also within tolerance.
//
// Ports
//   clk_in      in   1      system clock
//   rest        in   1      asynchronous reset, active-high
//   clk_mon     in   1      monitored clock, asynchronous, sampled as data
//   fault_clr   in   1      one-cycle pulse: leave fault, restart acquisition
//   period      out  CNT_W  last measured period in clk_in cycles
//   meas_valid  out  1      one-cycle pulse when period updates
//   locked      out  1      state == LOCKED
//   fault       out  1      state == FAULT
//   clk_stop    out  1      fault was entered through the stopped-clock timeout
//   state       out  2      IDLE=0 ACQ=1 LOCKED=2 FAULT=3
//   high_time   out  CNT_W  s2 high cycles within the last period
//                           (present only with CLKMON_DUTY_EN)
// -----------------------------------------------------------------------------
module clk_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 4,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk_in,
    input  logic             rest,
    input  logic             clk_mon,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             locked,
    output logic             fault,
    output logic             clk_stop,
    output logic [1:0]       state
`ifdef CLKMON_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam int              GC_W      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  LOCK_LAST = GC_W'(LOCK_CNT - 1);

    // Synchronizer (s1, s2) plus an edge-detect flop (s3)
    logic s1_q, s2_q, s3_q;
    logic rise;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             meas_valid_q, meas_valid_d;
    logic             clk_stop_q, clk_stop_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;

    logic cnt_at_limit;
    logic period_ok;
    logic good;

    assign rise         = s2_q & ~s3_q;
    assign cnt_at_limit = (cnt_q == TIMEOUT_C);
    assign period_ok    = (int'(cnt_q) >= EXP_PERIOD - TOL) &&
                          (int'(cnt_q) <= EXP_PERIOD + TOL);

`ifdef CLKMON_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             duty_ok;

    // |2*high - EXP_PERIOD| <= 2*TOL, written as two one-sided checks
    assign duty_ok = ((2 * int'(hcnt_q) - EXP_PERIOD) <= 2 * TOL) &&
                     ((EXP_PERIOD - 2 * int'(hcnt_q)) <= 2 * TOL);
    assign good    = period_ok && duty_ok;
`else
    assign good    = period_ok;
`endif

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        good_cnt_d   = good_cnt_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        clk_stop_d   = clk_stop_q;

        // The rise cycle itself is cycle 1 of the new period, so a /4 clock
        // reads back as 4 on the following rise.
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_at_limit) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

`ifdef CLKMON_DUTY_EN
        high_time_d = high_time_q;
        if (rise) begin
            hcnt_d = CNT_W'(1);
        end else if (s2_q && (hcnt_q != TIMEOUT_C)) begin
            hcnt_d = hcnt_q + 1'b1;
        end else begin
            hcnt_d = hcnt_q;
        end
`endif

        if (fault_clr) begin
            // Overrides a coincident rise: it is neither measured nor arms.
            state_d    = ST_IDLE;
            armed_d    = 1'b0;
            good_cnt_d = '0;
            clk_stop_d = 1'b0;
        end else begin
            if (rise && armed_q) begin
                period_d     = cnt_q;
                meas_valid_d = 1'b1;
`ifdef CLKMON_DUTY_EN
                high_time_d  = hcnt_q;
`endif
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d    = ST_ACQ;
                        armed_d    = 1'b1;
                        good_cnt_d = '0;
                    end
                end
                ST_ACQ: begin
                    // A rise on the timeout cycle wins over the timeout.
                    if (rise) begin
                        if (good) begin
                            if (good_cnt_q == LOCK_LAST) begin
                                state_d    = ST_LOCKED;
                                good_cnt_d = '0;
                            end else begin
                                good_cnt_d = good_cnt_q + 1'b1;
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end else if (cnt_at_limit) begin
                        state_d    = ST_IDLE;
                        armed_d    = 1'b0;
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (rise) begin
                        if (!good) begin
                            state_d = ST_FAULT;
                        end
                    end else if (cnt_at_limit) begin
                        state_d    = ST_FAULT;
                        clk_stop_d = 1'b1;
                    end
                end
                default: begin
                    // FAULT is sticky; measurements above keep running.
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk_in or posedge rest) begin
        if (rest) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            good_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            clk_stop_q   <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
`ifdef CLKMON_DUTY_EN
            hcnt_q       <= '0;
            high_time_q  <= '0;
`endif
        end else begin
            s1_q         <= clk_mon;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            good_cnt_q   <= good_cnt_d;
            state_q      <= state_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            clk_stop_q   <= clk_stop_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
`ifdef CLKMON_DUTY_EN
            hcnt_q       <= hcnt_d;
            high_time_q  <= high_time_d;
`endif
        end
    end

    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign fault      = fault_q;
    assign clk_stop   = clk_stop_q;
    assign state      = state_q;
`ifdef CLKMON_DUTY_EN
    assign high_time  = high_time_q;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_monitor
//
// Drives clk_mon as a sequence of (high, low) segments. An event-level model
// works from the gaps between rising edges: each gap is a period, long gaps are
// timeouts. Expected measurements go into a queue when the edge is driven; a
// separate monitor pops and compares whenever meas_valid is seen.
// -----------------------------------------------------------------------------
module tb_clk_monitor;

    localparam int CNT_W = 8;
    localparam int EXP   = 4;
    localparam int TOL   = 0;
    localparam int LOCK  = 4;
    localparam int TO    = 16;
    // clk_mon is sampled at the next edge, then two more flops: effect edge = drive + 3
    localparam int LAT   = 3;

    logic             clk_in = 1'b0;
    logic             rest;
    logic             clk_mon;
    logic             fault_clr;
    logic [CNT_W-1:0] period;
    logic             meas_valid;
    logic             locked;
    logic             fault;
    logic             clk_stop;
    logic [1:0]       state;
`ifdef CLKMON_DUTY_EN
    logic [CNT_W-1:0] high_time;
`endif

    clk_monitor #(
        .CNT_W     (CNT_W),
        .EXP_PERIOD(EXP),
        .TOL       (TOL),
        .LOCK_CNT  (LOCK),
        .TIMEOUT   (TO)
    ) dut (
        .clk_in    (clk_in),
        .rest      (rest),
        .clk_mon   (clk_mon),
        .fault_clr (fault_clr),
        .period    (period),
        .meas_valid(meas_valid),
        .locked    (locked),
        .fault     (fault),
        .clk_stop  (clk_stop),
        .state     (state)
`ifdef CLKMON_DUTY_EN
        ,
        .high_time (high_time)
`endif
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int p;
        int st;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    int m_state;
    bit m_armed;
    int m_good;
    bit m_stop;
    int m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_armed = 0;
        m_good  = 0;
        m_stop  = 0;
        m_last  = -1000;
        exp_q.delete();
    endtask

    // Apply a stopped-clock timeout if one fell on or before edge e.
    task automatic m_timeout_upto(input int e);
        if ((m_state == 1 || m_state == 2) && (e >= m_last + TO)) begin
            if (m_state == 1) begin
                m_state = 0;
                m_armed = 0;
                m_good  = 0;
            end else begin
                m_state = 3;
                m_stop  = 1;
            end
        end
    endtask

    task automatic m_rise(input int e, input bit clr);
        int p;
        bit g;
        m_timeout_upto(e - 1);
        if (clr) begin
            m_state = 0;
            m_armed = 0;
            m_good  = 0;
            m_stop  = 0;
            m_last  = e;
            return;
        end
        p = e - m_last;
        if (p > TO) p = TO;
        if (m_armed) begin
            g = (p >= EXP - TOL) && (p <= EXP + TOL);
            if (m_state == 1) begin
                if (g) begin
                    m_good++;
                    if (m_good == LOCK) m_state = 2;
                end else begin
                    m_good = 0;
                end
            end else if (m_state == 2) begin
                if (!g) m_state = 3;
            end
            exp_q.push_back('{p, m_state});
        end else begin
            m_state = 1;
            m_armed = 1;
            m_good  = 0;
        end
        m_last = e;
    endtask

    task automatic m_clr(input int e);
        m_timeout_upto(e - 1);
        m_state = 0;
        m_armed = 0;
        m_good  = 0;
        m_stop  = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        cyc++;
        #1;
    endtask

    // One clk_mon period: hi cycles high then lo low. With clr set, fault_clr
    // is pulsed on exactly the edge where this rise is detected.
    task automatic mon_period(input int hi, input int lo, input bit clr);
        m_rise(cyc + LAT, clr);
        for (int i = 0; i < hi + lo; i++) begin
            clk_mon = (i < hi);
            if (clr && i == LAT - 1) fault_clr = 1'b1;
            tick();
            fault_clr = 1'b0;
        end
    endtask

    task automatic hold_low(input int k);
        clk_mon = 1'b0;
        repeat (k) tick();
    endtask

    task automatic pulse_clr();
        m_clr(cyc + 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
    endtask

    task automatic check_state();
        m_timeout_upto(cyc);
        chk("state",    32'(state),    32'(m_state));
        chk("locked",   32'(locked),   32'(m_state == 2));
        chk("fault",    32'(fault),    32'(m_state == 3));
        chk("clk_stop", 32'(clk_stop), 32'(m_stop));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_period"},     32'(period),     32'd0);
        chk({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
        chk({tag, "_locked"},     32'(locked),     32'd0);
        chk({tag, "_fault"},      32'(fault),      32'd0);
        chk({tag, "_clk_stop"},   32'(clk_stop),   32'd0);
        chk({tag, "_state"},      32'(state),      32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk_in) begin
        if (rest === 1'b0 && meas_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_meas: got period=%0d state=%0d, required no measurement (cycle %0d)",
                         period, state, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("meas cycle=%0d period=%0d state=%0d model=%0d/%0d",
                         cyc, period, state, mon_e.p, mon_e.st);
                chk("meas_period", 32'(period), 32'(mon_e.p));
                chk("meas_state",  32'(state),  32'(mon_e.st));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, r;
        rest      = 1'b1;
        clk_mon   = 1'b0;
        fault_clr = 1'b0;
        model_reset();
        #1;
        check_zero("rst0");
        tick();
        tick();
        rest = 1'b0;
        hold_low(3);

        // /4 clock: lock on the 5th rise
        repeat (4) mon_period(2, 2, 0);
        check_state();
        mon_period(2, 2, 0);
        check_state();
        repeat (2) mon_period(2, 2, 0);

        // Switch to /10 while locked
        mon_period(5, 5, 0);
        check_state();

        // Stopped clock while locked, then clear
        pulse_clr();
        check_state();
        repeat (6) mon_period(2, 2, 0);
        hold_low(20);
        check_state();
        pulse_clr();
        check_state();

        // Gap exactly TIMEOUT: rise wins, bad period, no clk_stop
        repeat (6) mon_period(2, 2, 0);
        mon_period(2, 14, 0);
        mon_period(2, 2, 0);
        check_state();

        // In FAULT, fault_clr coincident with a rise
        mon_period(3, 1, 1);
        check_state();
        repeat (5) mon_period(2, 2, 0);
        check_state();

        // A 5-cycle period in ACQ after two good ones
        pulse_clr();
        mon_period(2, 2, 0);
        mon_period(2, 2, 0);
        mon_period(3, 2, 0);
        mon_period(2, 2, 0);
        repeat (3) mon_period(2, 2, 0);
        check_state();
        mon_period(2, 2, 0);
        check_state();

        // Asynchronous reset while locked
        @(negedge clk_in);
        #2;
        rest = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
        tick();
        tick();
        rest = 1'b0;
        hold_low(3);
        repeat (5) mon_period(2, 2, 0);
        check_state();

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                hi = 2;
                lo = 2;
            end else begin
                hi = $urandom_range(1, 6);
                lo = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(1, 6);
                if (hi + lo < 3) lo = 2;
            end
            mon_period(hi, lo, (hi >= 3) && ($urandom_range(0, 19) == 0));
            r = $urandom_range(0, 99);
            if (r < 12) check_state();
            else if (r < 17) pulse_clr();
        end

        hold_low(6);
        check_state();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
